// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues word fetches on a req/ack bus and queues {pc, instr} for decode.
// Latency: request 1 cycle after reset/redirect, decode sees the word the cycle after its ack.
// Backpressure: fetching pauses once the queue would fill; id_ready low holds the head stable.
module instr_fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    entry_t            mem [DEPTH];
    logic              xfer, push, pop;

    assign imem_req = (state != IDLE);
    assign xfer     = imem_req && imem_ack;
    assign pop      = id_valid && id_ready;
    // The full check is redundant with the room reservation but keeps storage safe.
    assign push     = (state == REQ) && xfer && !redirect && (count != DEPTH_C);

    assign count_next = redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));

    assign id_valid = (count != '0);
    assign id_instr = mem[rd_ptr].instr;
    assign id_pc    = mem[rd_ptr].pc;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = imem_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_next    = REQ;
                    fetch_pc_next = redirect_pc;
                    addr_next     = redirect_pc;
                end else if (count_next < DEPTH_C) begin
                    state_next = REQ;
                    addr_next  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    if (imem_ack) begin
                        addr_next = redirect_pc;
                    end else begin
                        // Bus request still open: address must hold until it completes.
                        state_next = DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_next = fetch_pc + ADDR_W'(1);
                    addr_next     = fetch_pc + ADDR_W'(1);
                    if (count_next >= DEPTH_C) begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end
                // The stale response completes here; restart at the latest target.
                if (imem_ack) begin
                    state_next = REQ;
                    addr_next  = fetch_pc_next;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= '0;
            imem_addr <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_addr <= addr_next;
            count     <= count_next;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue against a queue-based reference model,
// with directed phases for latency, stall, redirect and address wrap.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    instr_fetch_queue #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } ent_t;

    // Reference model: decode-visible queue plus the open bus request.
    ent_t       q[$];
    bit         m_pend;
    bit         m_drop;
    logic [7:0] m_addr;
    logic [7:0] m_npc;

    // Memory responder and stimulus knobs.
    int  wait_cnt, cur_lat, lat;
    bit  lat_rand;
    int  ready_pct, redir_pct;
    bit  redir_now;
    logic [7:0] redir_tgt;
    bit  req_s;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    task automatic model_clear();
        q.delete();
        m_pend   = 1'b0;
        m_drop   = 1'b0;
        m_addr   = 8'h00;
        m_npc    = 8'h00;
        wait_cnt = 0;
        cur_lat  = lat;
    endtask

    task automatic drive();
        req_s    = imem_req;
        id_ready = ($urandom_range(99) < ready_pct);
        imem_ack = req_s && (wait_cnt >= cur_lat);
        imem_rdata = imem_ack ? word_at(imem_addr) : 16'($urandom);
        if (redir_now) begin
            redirect    = 1'b1;
            redirect_pc = redir_tgt;
            redir_now   = 1'b0;
        end else begin
            redirect    = ($urandom_range(99) < redir_pct);
            redirect_pc = 8'($urandom);
        end
    endtask

    task automatic model_step();
        bit ack;
        ack = m_pend && imem_ack;
        if (req_s && imem_ack) begin
            wait_cnt = 0;
            cur_lat  = lat_rand ? int'($urandom_range(3)) : lat;
        end else if (req_s) begin
            wait_cnt++;
        end
        if (q.size() != 0 && id_ready) void'(q.pop_front());
        if (redirect) begin
            q.delete();
            m_npc = redirect_pc;
            if (m_pend && !ack) begin
                m_drop = 1'b1;
            end else begin
                m_pend = 1'b1;
                m_drop = 1'b0;
                m_addr = redirect_pc;
            end
        end else if (ack) begin
            if (m_drop) begin
                m_drop = 1'b0;
                m_addr = m_npc;
            end else begin
                q.push_back('{pc: m_addr, instr: word_at(m_addr)});
                m_npc  = m_addr + 8'd1;
                m_pend = (q.size() < DEPTH);
                m_addr = m_npc;
            end
        end else if (!m_pend && q.size() < DEPTH) begin
            m_pend = 1'b1;
            m_addr = m_npc;
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_pend});
        if (m_pend) chk("imem_addr", {24'b0, imem_addr}, {24'b0, m_addr});
        chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("id_pc", {24'b0, id_pc}, {24'b0, q[0].pc});
            chk("id_instr", {16'b0, id_instr}, {16'b0, q[0].instr});
        end
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        chk({tag, "_addr"},  {24'b0, imem_addr}, 32'd0);
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
        chk({tag, "_instr"}, {16'b0, id_instr}, 32'd0);
        chk({tag, "_pc"},    {24'b0, id_pc}, 32'd0);
    endtask

    // Called at a negedge; leaves reset released at a negedge.
    task automatic do_reset();
        reset = 1'b1;
        quiet_inputs();
        model_clear();
        #1 check_zero("rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        lat = 0; lat_rand = 1'b0; ready_pct = 100; redir_pct = 0; redir_now = 1'b0; redir_tgt = 8'h0;
        model_clear();
        repeat (2) @(negedge clk);

        // Zero-wait streaming.
        do_reset();
        cycle();
        chk("p1_req_c1", {31'b0, imem_req}, 32'd1);
        chk("p1_addr_c1", {24'b0, imem_addr}, 32'd0);
        cycle();
        chk("p1_valid_c2", {31'b0, id_valid}, 32'd1);
        chk("p1_pc_c2", {24'b0, id_pc}, 32'd0);
        chk("p1_instr_c2", {16'b0, id_instr}, 32'h1000);
        cycle();
        chk("p1_pc_c3", {24'b0, id_pc}, 32'd1);
        repeat (10) cycle();

        // Decode stalled: queue fills with PCs 0..3 and fetching pauses.
        ready_pct = 0;
        do_reset();
        repeat (10) cycle();
        chk("p2_req_low", {31'b0, imem_req}, 32'd0);
        chk("p2_head_pc", {24'b0, id_pc}, 32'd0);
        chk("p2_head_instr", {16'b0, id_instr}, 32'h1000);
        chk("p2_model_depth", q.size(), DEPTH);
        ready_pct = 100;
        cycle();
        chk("p2_resume_pc", {24'b0, id_pc}, 32'd1);
        chk("p2_resume_addr", {24'b0, imem_addr}, 32'd4);
        repeat (10) cycle();

        // Slow memory: one word per three cycles.
        lat = 2;
        do_reset();
        repeat (20) cycle();

        // Redirect while the PC-5 request is outstanding.
        lat = 0;
        do_reset();
        repeat (5) cycle();
        lat = 2;
        cycle();
        chk("p4_pend_addr", {24'b0, imem_addr}, 32'd5);
        redir_now = 1'b1; redir_tgt = 8'h40;
        cycle();
        chk("p4_flushed", {31'b0, id_valid}, 32'd0);
        chk("p4_drain_addr", {24'b0, imem_addr}, 32'd5);
        cycle();
        lat = 0;
        cycle();
        chk("p4_new_addr", {24'b0, imem_addr}, 32'h40);
        cycle();
        chk("p4_first_pc", {24'b0, id_pc}, 32'h40);
        chk("p4_first_instr", {16'b0, id_instr}, 32'h1040);
        repeat (3) cycle();

        // Redirect coinciding with an ack and a pop.
        redir_now = 1'b1; redir_tgt = 8'h80;
        cycle();
        chk("p5_flushed", {31'b0, id_valid}, 32'd0);
        chk("p5_addr", {24'b0, imem_addr}, 32'h80);
        cycle();
        chk("p5_first_pc", {24'b0, id_pc}, 32'h80);

        // Address wrap then asynchronous reset mid-stream.
        redir_now = 1'b1; redir_tgt = 8'hFE;
        cycle();
        cycle(); chk("p6_pc_fe", {24'b0, id_pc}, 32'hFE);
        cycle(); chk("p6_pc_ff", {24'b0, id_pc}, 32'hFF);
        cycle(); chk("p6_pc_00", {24'b0, id_pc}, 32'h00);
        cycle(); chk("p6_pc_01", {24'b0, id_pc}, 32'h01);
        drive();
        @(posedge clk);
        #2 reset = 1'b1;
        quiet_inputs();
        #1 check_zero("p6_async");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) cycle();

        // Randomised traffic.
        lat_rand = 1'b1; ready_pct = 70; redir_pct = 4;
        do_reset();
        repeat (3000) cycle();
        ready_pct = 25; redir_pct = 8;
        repeat (2000) cycle();
        ready_pct = 100; redir_pct = 2;
        repeat (1000) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
